// File: rtl/mux_scan_sequencer.sv
// Walks a 6-to-1 mux select through every input and collects the single-bit mux output
// into a parallel word, which is published with a one-cycle Done pulse.
module mux_scan_sequencer #(
    parameter int NUM_INPUTS = 6,
    parameter int SEL_WIDTH  = 3,
    parameter int DWELL      = 1,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  MuxOut,
    output logic [SEL_WIDTH-1:0]  MuxSelect,
    output logic                  Busy,
    output logic                  Done,
    output logic [NUM_INPUTS-1:0] Captured
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_INPUTS - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DWELL - 1);

    state_e                  state_q, state_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [NUM_INPUTS-1:0]   work_q, work_d;
    logic [NUM_INPUTS-1:0]   captured_q, captured_d;
    logic [SEL_WIDTH-1:0]    mux_select_q, mux_select_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            cnt_q        <= '0;
            work_q       <= '0;
            captured_q   <= '0;
            mux_select_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            work_q       <= work_d;
            captured_q   <= captured_d;
            mux_select_q <= mux_select_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // NOTE: every variable gets a default at the top of the block, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        captured_d = captured_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_SCAN;
                    sel_d   = '0;
                    cnt_d   = '0;
                    work_d  = '0;
                end
            end
            ST_SCAN: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d         = '0;
                    work_d[sel_q] = MuxOut;
                    // The final bit is merged here so Captured never shows a partial word.
                    if (sel_q == LAST_SEL) begin
                        captured_d = work_d;
                        state_d    = ST_DONE;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        busy_d       = (state_d == ST_SCAN);
        done_d       = (state_d == ST_DONE);
        mux_select_d = (state_d == ST_SCAN) ? sel_d : '0;
    end

    assign MuxSelect = mux_select_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Captured  = captured_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (DWELL=1 and DWELL=3) each drive a modelled
// 6-to-1 mux; expected words come from per-cycle input plans sampled at slot ends.
module tb_mux_scan_sequencer;

    localparam int N = 6;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         start   [2];
    logic [N-1:0] vec     [2];
    logic         mux_out [2];
    logic [2:0]   sel     [2];
    logic         busy    [2];
    logic         done    [2];
    logic [N-1:0] cap     [2];
    logic [N-1:0] exp_cap [2];
    logic [7:0]   pad0, pad1;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    // Behavioural 6-to-1 mux feeding each sequencer.
    assign pad0       = {2'b00, vec[0]};
    assign pad1       = {2'b00, vec[1]};
    assign mux_out[0] = pad0[sel[0]];
    assign mux_out[1] = pad1[sel[1]];

    mux_scan_sequencer #(.NUM_INPUTS(N), .SEL_WIDTH(3), .DWELL(1), .CNT_WIDTH(4)) u_d1 (
        .Clock(Clock), .Reset(Reset), .Start(start[0]), .MuxOut(mux_out[0]),
        .MuxSelect(sel[0]), .Busy(busy[0]), .Done(done[0]), .Captured(cap[0])
    );

    mux_scan_sequencer #(.NUM_INPUTS(N), .SEL_WIDTH(3), .DWELL(3), .CNT_WIDTH(4)) u_d3 (
        .Clock(Clock), .Reset(Reset), .Start(start[1]), .MuxOut(mux_out[1]),
        .MuxSelect(sel[1]), .Busy(busy[1]), .Done(done[1]), .Captured(cap[1])
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // plan[c] is the mux input word during scan cycle c; slot i is sampled at
    // the end of cycle (i+1)*dwell-1, so bit i of the result is plan[that cycle][i].
    task automatic run_scan(input int d, input int dwell, input logic [N-1:0] plan[$],
                            input int repulse, input string tag);
        logic [N-1:0] want;
        int total;
        total = N * dwell;
        want  = '0;
        for (int i = 0; i < N; i++) want[i] = plan[(i + 1) * dwell - 1][i];
        @(negedge Clock);
        start[d] = 1'b1;
        vec[d]   = plan[0];
        @(negedge Clock);
        start[d] = 1'b0;
        for (int c = 0; c < total; c++) begin
            if (c > 0) @(negedge Clock);
            check($sformatf("%s busy c%0d", tag, c), 32'(busy[d]), 32'd1);
            check($sformatf("%s sel c%0d", tag, c), 32'(sel[d]), 32'(c / dwell));
            check($sformatf("%s done_low c%0d", tag, c), 32'(done[d]), 32'd0);
            check($sformatf("%s cap_hold c%0d", tag, c), 32'(cap[d]), 32'(exp_cap[d]));
            vec[d]   = plan[c];
            start[d] = (c == repulse);
        end
        @(negedge Clock);
        start[d] = 1'b0;
        check({tag, " done_pulse"}, 32'(done[d]), 32'd1);
        check({tag, " busy_in_done"}, 32'(busy[d]), 32'd0);
        check({tag, " sel_in_done"}, 32'(sel[d]), 32'd0);
        check({tag, " captured"}, 32'(cap[d]), 32'(want));
        exp_cap[d] = want;
        @(negedge Clock);
        check({tag, " done_fall"}, 32'(done[d]), 32'd0);
        check({tag, " idle_busy"}, 32'(busy[d]), 32'd0);
        check({tag, " cap_after"}, 32'(cap[d]), 32'(want));
    endtask

    logic [N-1:0] plan[$];

    initial begin
        int done_cnt;
        int first_done;
        int last_done;
        int d;
        int dwell;
        int rep;

        Reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start[k]   = 1'b0;
            vec[k]     = '0;
            exp_cap[k] = '0;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset sel%0d", k), 32'(sel[k]), 32'd0);
            check($sformatf("reset busy%0d", k), 32'(busy[k]), 32'd0);
            check($sformatf("reset done%0d", k), 32'(done[k]), 32'd0);
            check($sformatf("reset cap%0d", k), 32'(cap[k]), 32'd0);
        end
        repeat (2) @(negedge Clock);
        Reset = 1'b0;

        // Basic DWELL=1 scan.
        plan.delete();
        for (int c = 0; c < N; c++) plan.push_back(6'b101101);
        run_scan(0, 1, plan, -1, "d1_basic");

        // DWELL=3 scan: each select held three cycles.
        plan.delete();
        for (int c = 0; c < 3 * N; c++) plan.push_back(6'b010011);
        run_scan(1, 3, plan, -1, "d3_basic");

        // Start re-pulsed during cycle 3 of a scan is ignored.
        plan.delete();
        for (int c = 0; c < 3 * N; c++) plan.push_back(6'b110110);
        run_scan(1, 3, plan, 3, "d3_repulse");

        // Input flips to all-ones right after slot 2 is sampled.
        plan.delete();
        for (int c = 0; c < N; c++) plan.push_back((c < 3) ? 6'b000000 : 6'b111111);
        run_scan(0, 1, plan, -1, "d1_change");
        check("d1_change literal", 32'(cap[0]), 32'h38);

        // Asynchronous reset mid-scan.
        @(negedge Clock);
        start[1] = 1'b1;
        vec[1]   = 6'b111111;
        @(negedge Clock);
        start[1] = 1'b0;
        repeat (4) @(negedge Clock);
        check("rst_mid busy_before", 32'(busy[1]), 32'd1);
        @(posedge Clock);
        #2 Reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_mid sel%0d", k), 32'(sel[k]), 32'd0);
            check($sformatf("rst_mid busy%0d", k), 32'(busy[k]), 32'd0);
            check($sformatf("rst_mid done%0d", k), 32'(done[k]), 32'd0);
            check($sformatf("rst_mid cap%0d", k), 32'(cap[k]), 32'd0);
            exp_cap[k] = '0;
        end
        @(negedge Clock);
        Reset = 1'b0;
        for (int k = 0; k < 3 * N + 2; k++) begin
            @(negedge Clock);
            check($sformatf("rst_mid no_done %0d", k), 32'(done[1]), 32'd0);
            check($sformatf("rst_mid stay_idle %0d", k), 32'(busy[1]), 32'd0);
        end
        plan.delete();
        for (int c = 0; c < 3 * N; c++) plan.push_back(6'b011010);
        run_scan(1, 3, plan, -1, "d3_after_rst");

        // Start held high: back-to-back scans, Done every 8 cycles.
        @(negedge Clock);
        vec[0]     = 6'b100001;
        start[0]   = 1'b1;
        done_cnt   = 0;
        first_done = -1;
        last_done  = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clock);
            if (k == 40) start[0] = 1'b0;
            if (done[0]) begin
                if (last_done >= 0)
                    check($sformatf("held period k%0d", k), 32'(k - last_done), 32'd8);
                else
                    first_done = k;
                check($sformatf("held cap k%0d", k), 32'(cap[0]), 32'h21);
                last_done = k;
                done_cnt++;
            end else if (first_done >= 0) begin
                check($sformatf("held cap_stable k%0d", k), 32'(cap[0]), 32'h21);
            end
        end
        check("held first_done", 32'(first_done), 32'(N + 1));
        check("held done_count", 32'(done_cnt), 32'd5);
        exp_cap[0] = 6'b100001;
        @(negedge Clock);
        check("held stopped", 32'(busy[0]), 32'd0);

        // Randomized scans with the mux input changing every cycle.
        for (int r = 0; r < 8; r++) begin
            d     = r % 2;
            dwell = (d == 1) ? 3 : 1;
            plan.delete();
            for (int c = 0; c < N * dwell; c++) plan.push_back(N'($urandom()));
            rep = ($urandom_range(1, 0) == 1) ? int'($urandom_range(N * dwell - 2, 0)) : -1;
            run_scan(d, dwell, plan, rep, $sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
